// File: rtl/io_pkg.sv
// Shared types and defaults for the mcpu IO peripherals.
//   uart_state_t            : UART transmitter FSM states
//   UART_CLK_DIV_DEFAULT    : clock cycles per bit (50 MHz / 115200 baud)
//   UART_FIFO_DEPTH_DEFAULT : transmit FIFO depth in bytes
package io_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam int unsigned UART_CLK_DIV_DEFAULT    = 434;
  localparam int unsigned UART_FIFO_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/fifo_sync.sv
// Synchronous FIFO with a combinational head output.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i        : write wdata_i (ignored while full)
//   pop_i         : drop the head entry (ignored while empty)
//   wdata_i       : write data
//   rdata_o       : current head entry
//   full_o        : holds Depth entries
//   empty_o       : holds no entries
//   count_o       : current occupancy
module fifo_sync #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [Width-1:0]       wdata_i,
  output logic [Width-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];

  // Fullness is judged on the registered count, so a same-cycle pop never frees room.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) begin
      mem_d[wptr_q] = wdata_i;
      wptr_d        = wptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + PtrW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/io_uart_tx.sv
// Byte-wide UART transmitter (8N1) for the mcpu IO write bus.
//   CLK     : system clock
//   RESET   : asynchronous active-low reset
//   WE, WD  : write strobe and byte; one byte queued per cycle while WE is high
//   OVF_CLR : synchronous clear of the sticky overflow flag
//   TXD     : serial output, idle high, registered
//   FULL, EMPTY, COUNT : FIFO status from the registered occupancy
//   BUSY    : FSM is not idle
//   OVF     : sticky, set when a write hits a full FIFO
module io_uart_tx
  import io_pkg::*;
#(
  parameter int unsigned CLK_DIV = UART_CLK_DIV_DEFAULT,
  parameter int unsigned DEPTH   = UART_FIFO_DEPTH_DEFAULT
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   WE,
  input  logic [7:0]             WD,
  input  logic                   OVF_CLR,
  output logic                   TXD,
  output logic                   FULL,
  output logic                   EMPTY,
  output logic                   BUSY,
  output logic                   OVF,
  output logic [$clog2(DEPTH):0] COUNT
);

  localparam int unsigned BaudW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLK_DIV - 1);

  uart_state_t      state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       sh_q, sh_d;
  logic             txd_q, txd_d;
  logic             busy_q, busy_d;
  logic             ovf_q, ovf_d;

  logic       fifo_pop;
  logic [7:0] fifo_rdata;
  logic       fifo_full, fifo_empty;
  logic       bit_end;

  fifo_sync #(
    .Width(8),
    .Depth(DEPTH)
  ) u_fifo (
    .clk_i  (CLK),
    .rst_ni (RESET),
    .push_i (WE),
    .pop_i  (fifo_pop),
    .wdata_i(WD),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(COUNT)
  );

  assign FULL  = fifo_full;
  assign EMPTY = fifo_empty;
  assign TXD   = txd_q;
  assign BUSY  = busy_q;
  assign OVF   = ovf_q;

  assign bit_end = (baud_q == BaudLast);

  // A dropped write takes priority over a clear in the same cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (WE && fifo_full) begin
      ovf_d = 1'b1;
    end else if (OVF_CLR) begin
      ovf_d = 1'b0;
    end
  end

  // TXD is computed one cycle ahead so the pin itself comes straight from a flop.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    idx_d    = idx_q;
    sh_d     = sh_q;
    txd_d    = txd_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          sh_d     = fifo_rdata;
          baud_d   = '0;
          state_d  = START;
          txd_d    = 1'b0;
        end
      end
      START: begin
        txd_d = 1'b0;
        if (bit_end) begin
          baud_d  = '0;
          idx_d   = '0;
          state_d = DATA;
          txd_d   = sh_q[0];
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      DATA: begin
        txd_d = sh_q[0];
        if (bit_end) begin
          baud_d = '0;
          sh_d   = {1'b0, sh_q[7:1]};
          idx_d  = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            txd_d = sh_q[1];
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      STOP: begin
        txd_d = 1'b1;
        if (bit_end) begin
          baud_d = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            sh_d     = fifo_rdata;
            state_d  = START;
            txd_d    = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed self-checking bench for io_uart_tx with CLK_DIV=4, DEPTH=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_io_uart_tx;

  logic       clk;
  logic       rst_n;
  logic       we;
  logic [7:0] wd;
  logic       ovf_clr;
  logic       txd, full, empty, busy, ovf;
  logic [2:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  io_uart_tx #(
    .CLK_DIV(4),
    .DEPTH  (4)
  ) dut (
    .CLK    (clk),
    .RESET  (rst_n),
    .WE     (we),
    .WD     (wd),
    .OVF_CLR(ovf_clr),
    .TXD    (txd),
    .FULL   (full),
    .EMPTY  (empty),
    .BUSY   (busy),
    .OVF    (ovf),
    .COUNT  (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Line level of 8N1 frame bit b (0 = start, 1..8 = data LSB first, 9 = stop).
  function automatic logic frame_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return d[b-1];
  endfunction

  int cexp[6] = '{1, 1, 2, 3, 4, 4};

  initial begin
    rst_n   = 1'b1;
    we      = 1'b0;
    wd      = 8'h00;
    ovf_clr = 1'b0;

    // Reset values, checked while reset is held low
    #2 rst_n = 1'b0;
    #1;
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single byte 0xA5
    we = 1'b1;
    wd = 8'hA5;
    tick();
    we = 1'b0;
    check("single_count_push", 32'(count), 32'd1);
    check("single_txd_idle", 32'(txd), 32'd1);
    tick();
    check("single_count_pop", 32'(count), 32'd0);
    check("single_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 40; i++) begin
      check($sformatf("single_txd_%0d", i), 32'(txd), 32'(frame_bit(8'hA5, i / 4)));
      tick();
    end
    check("single_busy_end", 32'(busy), 32'd0);
    check("single_empty_end", 32'(empty), 32'd1);
    check("single_txd_end", 32'(txd), 32'd1);

    // Back-to-back 0x00, 0xFF
    we = 1'b1;
    wd = 8'h00;
    tick();
    check("b2b_count_k", 32'(count), 32'd1);
    wd = 8'hFF;
    tick();
    we = 1'b0;
    for (int i = 0; i < 80; i++) begin
      check($sformatf("b2b_txd_%0d", i), 32'(txd),
            32'(frame_bit((i < 40) ? 8'h00 : 8'hFF, (i % 40) / 4)));
      if (i == 0 || i == 38 || i == 39) check($sformatf("b2b_count_%0d", i), 32'(count), 32'd1);
      if (i == 40) check("b2b_count_pop2", 32'(count), 32'd0);
      tick();
    end
    check("b2b_busy_end", 32'(busy), 32'd0);
    check("b2b_empty_end", 32'(empty), 32'd1);

    // Overflow: 0x10..0x15 on six consecutive edges
    we = 1'b1;
    for (int j = 0; j < 6; j++) begin
      wd = 8'(8'h10 + j);
      tick();
      check($sformatf("ovf_count_%0d", j), 32'(count), 32'(cexp[j]));
      if (j == 4) begin
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_not_yet", 32'(ovf), 32'd0);
      end
      if (j == 5) check("ovf_set", 32'(ovf), 32'd1);
    end
    we = 1'b0;
    for (int i = 4; i < 200; i++) begin
      check($sformatf("ovf_txd_%0d", i), 32'(txd),
            32'(frame_bit(8'(8'h10 + i / 40), (i % 40) / 4)));
      tick();
    end
    check("ovf_busy_end", 32'(busy), 32'd0);
    check("ovf_empty_end", 32'(empty), 32'd1);
    check("ovf_sticky", 32'(ovf), 32'd1);

    // OVF clear, and set winning over a simultaneous clear
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("clr_ovf", 32'(ovf), 32'd0);
    we = 1'b1;
    for (int j = 0; j < 5; j++) begin
      wd = 8'(8'h20 + j);
      tick();
    end
    check("clr_fill_count", 32'(count), 32'd4);
    check("clr_fill_ovf", 32'(ovf), 32'd0);
    wd = 8'h25;
    tick();
    check("clr_drop_ovf", 32'(ovf), 32'd1);
    wd      = 8'h26;
    ovf_clr = 1'b1;
    tick();
    check("clr_race_ovf", 32'(ovf), 32'd1);
    check("clr_race_count", 32'(count), 32'd4);
    we = 1'b0;
    tick();
    ovf_clr = 1'b0;
    check("clr_again_ovf", 32'(ovf), 32'd0);

    // Reset mid-frame with two bytes queued
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    we = 1'b1;
    wd = 8'h30;
    tick();
    wd = 8'h31;
    tick();
    wd = 8'h32;
    tick();
    we = 1'b0;
    for (int i = 2; i < 17; i++) tick();
    check("mid_txd_bit3", 32'(txd), 32'd0);
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_count", 32'(count), 32'd2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_txd", 32'(txd), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_count", 32'(count), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      check($sformatf("post_rst_txd_%0d", i), 32'(txd), 32'd1);
    end
    check("post_rst_empty", 32'(empty), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
